rr_mux_arbiter: RTL

Round-robin arbiter that shares one 4:1 select path between four requesters. It grants one requester at a time and drives the 2-bit mux select. It forwards the granted requester's data with a valid flag. It sits in front of the 4x1 mux datapath and owns its select lines, so downstream logic sees one arbitrated stream.

---
 rtl/rr_mux_arbiter_if.sv | 22 ++
 rtl/rr_mux_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter_if.sv
// Request/grant/data bundle between four requesters and the round-robin mux arbiter.
interface rr_mux_arbiter_if #(
  parameter int DATA_W = 1
);
  logic [3:0]          req;
  logic [4*DATA_W-1:0] din;
  logic [3:0]          gnt;
  logic [1:0]          sel;
  logic [DATA_W-1:0]   dout;
  logic                dout_valid;
  logic                busy;

  modport master (
    output req, din,
    input  gnt, sel, dout, dout_valid, busy
  );

  modport slave (
    input  req, din,
    output gnt, sel, dout, dout_valid, busy
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 mux; forwards the granted slice.
// Optional macro FIXED_PRIO_EN: search always starts at requester 0 (fixed priority 0>1>2>3).
module rr_mux_arbiter #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  rr_mux_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [7:0]  hold_q, hold_d;
  logic [1:0]  base;
  logic [2:0]  cand;
  logic        search;
  logic        release_w;

  // Returns {found, index} of the first asserted request at or after base, wrapping mod 4.
  function automatic logic [2:0] find_cand(input logic [3:0] r, input logic [1:0] b);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = b + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
    end
  end

  assign release_w = !bus.req[sel_q] || (hold_q == HOLD_MAX);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    base    = ptr_q;
    search  = 1'b0;
    case (state_q)
      IDLE: search = 1'b1;
      OWN: begin
        // Releasing requester moves to the back of the rotation before the same-edge search.
        if (release_w) begin
          search = 1'b1;
          ptr_d  = sel_q + 2'd1;
          base   = sel_q + 2'd1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: search = 1'b1;
    endcase
`ifdef FIXED_PRIO_EN
    base  = 2'd0;
    ptr_d = 2'd0;
`else
`endif
    cand = find_cand(bus.req, base);
    if (search) begin
      if (cand[2]) begin
        state_d = OWN;
        sel_d   = cand[1:0];
        gnt_d   = 4'b0001 << cand[1:0];
        hold_d  = 8'd1;
      end else begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        hold_d  = 8'd0;
      end
    end
  end

  always_comb begin
    bus.gnt        = gnt_q;
    bus.sel        = sel_q;
    bus.dout_valid = (state_q == OWN);
    bus.busy       = (state_q == OWN);
    bus.dout       = '0;
    if (state_q == OWN) bus.dout = bus.din[sel_q*DATA_W +: DATA_W];
  end

endmodule
